// File: rtl/ixu_issue_stage_if.sv
// ixu_issue_stage_if
// Decode-to-issue handshake bundle: one decoded integer instruction per cycle.
//   in_valid        decoded instruction present (decoder -> issue)
//   in_ready        issue stage can accept this cycle (issue -> decoder)
//   in_rd/in_rs1/in_rs2  destination and source register indices
//   in_imm          raw 12-bit immediate
//   in_is_imm_type  second operand comes from the immediate
//   in_op           4-bit ALU op code
// master modport: decoder side. slave modport: issue stage side.
interface ixu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        in_is_imm_type;
  logic [3:0]  in_op;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_imm, in_is_imm_type, in_op,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_imm, in_is_imm_type, in_op,
    output in_ready
  );
endinterface

// File: rtl/ixu_issue_stage.sv
// ixu_issue_stage
// Issue stage in front of the integer execute stage. Captures one decoded
// instruction per cycle into the EX register, resolves RAW hazards against
// the instructions in EX and WB, and owns the one-entry writeback register
// that feeds both the forwarding path and the register-file write port.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   stall, flush        hold all stage registers / kill incoming and EX
//   dec                 decode handshake (slave side)
//   rf_rs1_data/rs2     asynchronous register-file read of in_rs1/in_rs2
//   ex_out              combinational result of the execute stage
//   rs1_data/rs2_data, is_rs1_fwd/is_rs2_fwd, rs1_fwd_data/rs2_fwd_data,
//   imm, is_imm_type, op, is_nop   registered execute-stage inputs
//   wb_valid, wb_rd, wb_data       writeback register / register-file write
module ixu_issue_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  ixu_issue_stage_if.slave   dec,
  input  logic [31:0]        rf_rs1_data,
  input  logic [31:0]        rf_rs2_data,
  input  logic [31:0]        ex_out,
  output logic [31:0]        rs1_data,
  output logic [31:0]        rs2_data,
  output logic               is_rs1_fwd,
  output logic               is_rs2_fwd,
  output logic [31:0]        rs1_fwd_data,
  output logic [31:0]        rs2_fwd_data,
  output logic [11:0]        imm,
  output logic               is_imm_type,
  output logic [3:0]         op,
  output logic               is_nop,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data
);

  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [32:0] rs1_res;
  logic [32:0] rs2_res;

  // Returns {fwd, data}. The instruction in EX is younger than the one in WB,
  // so it is checked first. An EX hit forwards because its result only lands
  // in wb_data on the next edge; a WB hit is captured now because the
  // register file is written on this same edge and the read is stale.
  function automatic logic [32:0] resolve(
    input logic [4:0]  src,
    input logic [31:0] rf_data,
    input logic        ex_v,
    input logic [4:0]  ex_d,
    input logic        wb_v,
    input logic [4:0]  wb_d,
    input logic [31:0] wb_q
  );
    if (src == 5'd0)
      resolve = {1'b0, rf_data};
    else if (ex_v && (ex_d == src))
      resolve = {1'b1, rf_data};
    else if (wb_v && (wb_d == src))
      resolve = {1'b0, wb_q};
    else
      resolve = {1'b0, rf_data};
  endfunction

  always_comb begin
    rs1_res = resolve(dec.in_rs1, rf_rs1_data, ex_valid, ex_rd, wb_valid, wb_rd, wb_data);
    rs2_res = resolve(dec.in_rs2, rf_rs2_data, ex_valid, ex_rd, wb_valid, wb_rd, wb_data);
  end

  assign dec.in_ready = !stall;
  assign is_nop       = !ex_valid;
  assign rs1_fwd_data = wb_data;
  assign rs2_fwd_data = wb_data;

  // Flush kills EX unconditionally; WB is only killed when it would otherwise
  // advance, since under stall it still holds the older, committed instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rd       <= 5'd0;
      rs1_data    <= 32'd0;
      rs2_data    <= 32'd0;
      imm         <= 12'd0;
      is_imm_type <= 1'b0;
      op          <= 4'd0;
      is_rs1_fwd  <= 1'b0;
      is_rs2_fwd  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_rd       <= 5'd0;
      rs1_data    <= 32'd0;
      rs2_data    <= 32'd0;
      imm         <= 12'd0;
      is_imm_type <= 1'b0;
      op          <= 4'd0;
      is_rs1_fwd  <= 1'b0;
      is_rs2_fwd  <= 1'b0;
      if (!stall) begin
        wb_valid <= 1'b0;
        wb_rd    <= 5'd0;
        wb_data  <= 32'd0;
      end
    end else if (!stall) begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      wb_data  <= ex_out;
      if (dec.in_valid) begin
        ex_valid    <= 1'b1;
        ex_rd       <= dec.in_rd;
        rs1_data    <= rs1_res[31:0];
        rs2_data    <= rs2_res[31:0];
        imm         <= dec.in_imm;
        is_imm_type <= dec.in_is_imm_type;
        op          <= dec.in_op;
        is_rs1_fwd  <= rs1_res[32];
        is_rs2_fwd  <= rs2_res[32];
      end else begin
        ex_valid    <= 1'b0;
        ex_rd       <= 5'd0;
        rs1_data    <= 32'd0;
        rs2_data    <= 32'd0;
        imm         <= 12'd0;
        is_imm_type <= 1'b0;
        op          <= 4'd0;
        is_rs1_fwd  <= 1'b0;
        is_rs2_fwd  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ixu_issue_stage.md
# ixu_issue_stage

Pipeline stage directly upstream of the integer execute stage. It accepts one decoded integer instruction per cycle and reads operands from the register file. It detects RAW hazards against the two older in-flight instructions and drives the execute-stage operand, immediate, op and forwarding inputs from registers. It also holds the one-entry writeback register that captures the execute result and supplies both the forwarding data and the register-file write port.

## Interface
- No parameters. Widths are fixed: XLEN 32, register index 5, imm 12, op 4.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  kill incoming instruction and instruction in EX
- in_valid  in  1  decoded instruction present
- in_ready  out  1  = !stall; transfer when in_valid && in_ready
- in_rd / in_rs1 / in_rs2  in  5 each  destination / source register indices
- in_imm  in  12  raw immediate
- in_is_imm_type  in  1  use immediate as second operand
- in_op  in  4  ALU op code (0x0..0x9)
- rf_rs1_data / rf_rs2_data  in  32 each  asynchronous register-file read of in_rs1 / in_rs2
- ex_out  in  32  combinational result from execute stage
- rs1_data / rs2_data  out  32 each  registered operands to execute
- is_rs1_fwd / is_rs2_fwd  out  1 each  execute selects rs*_fwd_data
- rs1_fwd_data / rs2_fwd_data  out  32 each  both driven by wb_data
- imm  out  12;  is_imm_type  out  1;  op  out  4;  is_nop  out  1  registered to execute
- wb_valid  out  1;  wb_rd  out  5;  wb_data  out  32  register-file write, committed at clock edge when wb_valid && wb_rd != 0

## Operation
- EX register fields: valid (is_nop = !valid), rd, rs1_data, rs2_data, imm, is_imm_type, op, is_rs1_fwd, is_rs2_fwd.
- WB register fields: wb_valid, wb_rd, wb_data.
- Per-edge priority: reset > flush > stall > normal.
- Normal edge (!stall, !flush):
  - WB <= {EX valid, EX rd, ex_out}.
  - EX <= incoming instruction if in_valid, else bubble. A bubble has valid=0, with data, imm, op and fwd flags all 0.
- Stall edge (no flush): EX and WB hold. in_ready=0, so nothing is accepted.
- Flush edge:
  - EX <= bubble.
  - Without stall, WB <= bubble, so the EX instruction is killed.
  - With stall, WB holds; it is the older, committed instruction.
- Hazard resolution for each source s in {rs1, rs2} on an accepting edge. The checks are evaluated in order; the first match wins.
  - Case 1: in_s == 0 → data = rf data, fwd = 0. x0 is never forwarded.
  - Case 2: EX valid && EX rd == in_s → fwd = 1, data = rf data (don't care). The producer is in WB next cycle, so fwd data = wb_data.
  - Case 3: wb_valid && wb_rd == in_s → data = wb_data, fwd = 0. The register file is written on this same edge, so the read is stale.
  - Otherwise → data = rf data, fwd = 0.
- Immediate is passed raw. Sign extension and 5-bit shift-amount selection are done by execute.
- The op code is passed unchecked; invalid ops are reported by execute.

## Timing
- Reset (rst_n=0 at edge) values:
  - is_nop=1.
  - rs1_data, rs2_data, imm, op, is_imm_type, is_rs1_fwd, is_rs2_fwd all 0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - in_ready follows stall combinationally.
- Instruction accepted at edge N:
  - In EX during cycle N..N+1.
  - Result in wb_data after edge N+1.
  - Register file updated at edge N+2.
- Back-to-back dependent instructions issue with zero bubbles.
- rs*_fwd_data = wb_data combinationally from register; no added latency.
- While stalled, forwarding stays valid because EX and WB hold together. Repeated register-file writes of the same WB entry are idempotent.
- Reset mid-stall or mid-flush: reset wins; all in-flight state is discarded.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → is_nop=1, wb_valid=0, all outputs 0. First instruction is accepted on the first edge after release.
- EX forwarding:
  - Stimulus: ADDI x5,x0,7, then ADD x6,x5,x5 on the next cycle.
  - Required response: second instruction in EX with is_rs1_fwd=is_rs2_fwd=1 and wb_data=7. Next cycle wb_rd=6, wb_data=14.
- WB capture:
  - Stimulus: ADDI x5,x0,3, one bubble, then SUB x7,x5,x0 with rf_rs1_data=0 (stale).
  - Required response: rs1_data=3, is_rs1_fwd=0, and the resulting wb_data=3.
- x0 and priority:
  - Stimulus: write x0 (rd=0), then consume x0 → no forward, rs1_data = rf data, and no register-file write (wb_rd=0).
  - Stimulus: EX and WB both target x5 → EX forwarding selected.
- Stall: assert stall for 3 cycles with a dependent pair in EX/WB → in_ready=0, all outputs unchanged. After release, results match the unstalled sequence.
- Flush:
  - Stimulus: flush with instruction A in WB and B in EX, stall=0 → next cycle is_nop=1, wb_valid=0.
  - Stimulus: same, with stall=1 → WB keeps A, EX becomes bubble.
